// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_pkg : shared types for the chunked add/subtract unit          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chunk_adder : combinational ripple adder for one CHUNK-bit slice     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  // cmsb is the carry entering the slice MSB; for the top slice it feeds overflow
  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_seq : multi-cycle add/subtract, CHUNK bits per clock, LSB     |
// | first. Optional ADDSUB_SAT_EN clamps z to a signed limit on overflow.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cOut,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  addsub_state_t    state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic             carry_q;
  logic [WIDTH-1:0] psum;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;
  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] z_next;
  logic             ovf_next;
  logic             is_sub;

  assign is_sub  = (addsub_op_t'(op) == OP_SUB);
  assign slice_a = a_q[cnt*CHUNK +: CHUNK];
  assign slice_b = bx_q[cnt*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x    (slice_a),
    .y    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  // Partial sum with the current slice merged in; on the last chunk this is the full result
  always_comb begin
    sum_full = psum;
    sum_full[cnt*CHUNK +: CHUNK] = slice_s;
  end

  assign ovf_next = slice_cmsb ^ slice_cout;

`ifdef ADDSUB_SAT_EN
  always_comb begin
    z_next = sum_full;
    if (ovf_next) begin
      z_next = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign z_next = sum_full;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      bx_q     <= '0;
      carry_q  <= 1'b0;
      psum     <= '0;
      z        <= '0;
      cOut     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            bx_q    <= is_sub ? ~b : b;
            carry_q <= is_sub;
            cnt     <= '0;
            psum    <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          psum    <= sum_full;
          carry_q <= slice_cout;
          if (cnt == LAST) begin
            cnt      <= '0;
            z        <= z_next;
            cOut     <= slice_cout;
            overflow <= ovf_next;
            zero     <= (z_next == '0);
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule
`default_nettype wire
